// File: rtl/vga_timing_monitor.sv
// Receiver-side VGA timing monitor: rebuilds pixel coordinates from HS/VS, checks timing, tracks lock.
// Optional per-frame pixel checksum on frame_sum when VGA_MON_CHECKSUM_EN is defined.
module vga_timing_monitor #(
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_TOTAL  = 525,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned RGB_W    = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             pix_en,
  input  logic             vga_hs,
  input  logic             vga_vs,
  input  logic [RGB_W-1:0] vga_r,
  input  logic [RGB_W-1:0] vga_g,
  input  logic [RGB_W-1:0] vga_b,
  input  logic             clr_err,
  output logic [9:0]       px_x,
  output logic [9:0]       px_y,
  output logic             px_valid,
  output logic             locked,
  output logic             frame_done,
  output logic [ERR_W-1:0] hs_err_cnt,
  output logic [ERR_W-1:0] vs_err_cnt,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      frame_sum
);

  localparam logic [10:0] HSyncLast = 11'(H_SYNC - 1);
  localparam logic [10:0] HLineLast = 11'(H_TOTAL - 1);
  localparam logic [10:0] HTmoLast  = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] HActLo    = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HActHi    = 11'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]  VSyncLen  = 10'(V_SYNC);
  localparam logic [9:0]  VFrmLast  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VActLo    = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]  VActHi    = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [ERR_W-1:0] ErrOne = {{(ERR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

  state_e      state_q, state_d;
  logic        hs_q, vs_q;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        line_seen_q, line_seen_d;
  logic        frame_ok_q, frame_ok_d;
  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic        timeout, hs_err, vs_err, any_err, active, good_frame, count_en;

  assign hs_fall = pix_en & hs_q & ~vga_hs;
  assign hs_rise = pix_en & ~hs_q & vga_hs;
  assign vs_fall = pix_en & vs_q & ~vga_vs;
  assign vs_rise = pix_en & ~vs_q & vga_vs;

  always_comb begin
    hcnt_d = hcnt_q;
    if (hs_fall) begin
      hcnt_d = '0;
    end else if (pix_en && hcnt_q != '1) begin
      hcnt_d = hcnt_q + 11'd1;
    end
    vcnt_d = vcnt_q;
    if (vs_fall) begin
      vcnt_d = '0;
    end else if (hs_fall) begin
      vcnt_d = vcnt_q + 10'd1;
    end
  end

  // Line length is only meaningful once an HS fall has anchored hcnt.
  assign timeout = pix_en & ~hs_fall & (hcnt_q == HTmoLast);
  assign hs_err  = (hs_rise & (hcnt_q != HSyncLast)) |
                   (hs_fall & line_seen_q & (hcnt_q != HLineLast)) | timeout;
  assign vs_err  = (vs_rise & (vcnt_d != VSyncLen)) | (vs_fall & (vcnt_q != VFrmLast));
  assign any_err = hs_err | vs_err;
  assign active  = (hcnt_d >= HActLo) && (hcnt_d < HActHi) &&
                   (vcnt_d >= VActLo) && (vcnt_d < VActHi);
  assign count_en = (state_q != StUnlocked);
  assign locked   = (state_q == StLocked);

  always_comb begin
    state_d     = state_q;
    frame_ok_d  = frame_ok_q;
    good_frame  = 1'b0;
    line_seen_d = line_seen_q | hs_fall;
    if (pix_en) begin
      case (state_q)
        // Entered on a VS fall, so the frame that follows is fully observed.
        StUnlocked: begin
          if (vs_fall) begin
            state_d    = StAcquire;
            frame_ok_d = 1'b1;
          end
        end
        StAcquire: begin
          if (vs_fall) begin
            if (frame_ok_q && !any_err) begin
              state_d    = StLocked;
              good_frame = 1'b1;
            end else begin
              frame_ok_d = 1'b1;
            end
          end else if (any_err) begin
            frame_ok_d = 1'b0;
          end
        end
        StLocked: begin
          if (any_err) begin
            state_d    = StAcquire;
            frame_ok_d = 1'b0;
          end else if (vs_fall) begin
            good_frame = 1'b1;
          end
        end
        default: state_d = StUnlocked;
      endcase
      if (timeout) begin
        state_d     = StUnlocked;
        good_frame  = 1'b0;
        line_seen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StUnlocked;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      line_seen_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_valid    <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      hs_err_cnt  <= '0;
      vs_err_cnt  <= '0;
    end else begin
      frame_done <= good_frame;
      if (clr_err) begin
        hs_err_cnt <= '0;
        vs_err_cnt <= '0;
      end else begin
        if (count_en && hs_err && !(&hs_err_cnt)) hs_err_cnt <= hs_err_cnt + ErrOne;
        if (count_en && vs_err && !(&vs_err_cnt)) vs_err_cnt <= vs_err_cnt + ErrOne;
      end
      if (pix_en) begin
        state_q     <= state_d;
        hs_q        <= vga_hs;
        vs_q        <= vga_vs;
        hcnt_q      <= hcnt_d;
        vcnt_q      <= vcnt_d;
        line_seen_q <= line_seen_d;
        frame_ok_q  <= frame_ok_d;
        px_valid    <= active && (state_q == StLocked);
        if (active) begin
          px_x <= 10'(hcnt_d - HActLo);
          px_y <= vcnt_d - VActLo;
        end
        if (good_frame) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

`ifdef VGA_MON_CHECKSUM_EN
  logic [15:0] acc_q, sum_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      acc_q <= '0;
      sum_q <= '0;
    end else if (pix_en) begin
      if (vs_fall) begin
        acc_q <= '0;
      end else if (active) begin
        acc_q <= acc_q + 16'({vga_r, vga_g, vga_b});
      end
      if (good_frame) sum_q <= acc_q;
    end
  end

  assign frame_sum = sum_q;
`else
  logic unused_rgb;
  assign unused_rgb = ^{vga_r, vga_g, vga_b};
  assign frame_sum  = '0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed-scenario bench for vga_timing_monitor using a scaled-down raster to keep runs short.
module tb_vga_timing_monitor;
  localparam int HT = 40, HS = 4, HB = 4, HA = 24;
  localparam int VT = 20, VS = 2, VB = 3, VA = 12;

  logic        Clk = 1'b0, Reset_n = 1'b0, pix_en = 1'b0, clr_err = 1'b0;
  logic        vga_hs = 1'b1, vga_vs = 1'b1;
  logic [3:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic [9:0]  px_x, px_y;
  logic        px_valid, locked, frame_done;
  logic [7:0]  hs_err_cnt, vs_err_cnt;
  logic [15:0] frame_cnt, frame_sum;

  int          n_assert = 0, n_fail = 0;
  int          clr_v = -1, clr_h = -1;
  logic [15:0] cur_sum = '0, last_sum = '0;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA),
    .RGB_W(4), .ERR_W(8)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .clr_err(clr_err),
    .px_x(px_x), .px_y(px_y), .px_valid(px_valid), .locked(locked), .frame_done(frame_done),
    .hs_err_cnt(hs_err_cnt), .vs_err_cnt(vs_err_cnt), .frame_cnt(frame_cnt),
    .frame_sum(frame_sum)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_act(input int h, input int v);
    return h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
  endfunction

  function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef VGA_MON_CHECKSUM_EN
    return s;
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_zero(input string when);
    chk({when, " px_x"}, px_x, 0);
    chk({when, " px_y"}, px_y, 0);
    chk({when, " px_valid"}, px_valid, 0);
    chk({when, " locked"}, locked, 0);
    chk({when, " frame_done"}, frame_done, 0);
    chk({when, " hs_err_cnt"}, hs_err_cnt, 0);
    chk({when, " vs_err_cnt"}, vs_err_cnt, 0);
    chk({when, " frame_cnt"}, frame_cnt, 0);
    chk({when, " frame_sum"}, frame_sum, 0);
  endtask

  // One pixel-enable sample; returns at the falling edge after it was captured.
  task automatic drive(input logic hs, input logic vs, input logic [11:0] rgb, input logic clr);
    repeat ($urandom_range(0, 1)) @(negedge Clk);
    pix_en = 1'b1;
    vga_hs = hs;
    vga_vs = vs;
    {vga_r, vga_g, vga_b} = rgb;
    clr_err = clr;
    @(negedge Clk);
    pix_en  = 1'b0;
    clr_err = 1'b0;
  endtask

  // mode: 1 = expect locked pixel output, 0 = expect px_valid low, -1 = no pixel checks
  task automatic send_line(input int v, input int len, input int hsw, input int vsw,
                           input int mode, input bit done_exp, input bit const_rgb);
    logic [11:0] rgb;
    for (int h = 0; h < len; h++) begin
      rgb = const_rgb ? 12'hFFF : 12'($urandom);
      if (is_act(h, v)) cur_sum = cur_sum + 16'(rgb);
      drive(h >= hsw, v >= vsw, rgb, v == clr_v && h == clr_h);
      chk("frame_done", frame_done, done_exp && h == 0);
      if (done_exp && h == 0) chk("frame_sum", frame_sum, exp_sum(last_sum));
      if (mode == 0) chk("px_valid idle", px_valid, 0);
      if (mode == 1) begin
        chk("px_valid", px_valid, is_act(h, v));
        if (is_act(h, v)) begin
          chk("px_x", px_x, h - HS - HB);
          chk("px_y", px_y, v - VS - VB);
        end
      end
    end
  endtask

  task automatic send_frame(input int vsw, input int bad_v, input int bad_len, input int bad_hsw,
                            input int mode, input bit done_exp, input bit const_rgb);
    cur_sum = '0;
    for (int v = 0; v < VT; v++) begin
      send_line(v, (v == bad_v) ? bad_len : HT, (v == bad_v) ? bad_hsw : HS, vsw, mode,
                done_exp && v == 0, const_rgb);
    end
    last_sum = cur_sum;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check_zero("reset");
    Reset_n = 1'b1;
    @(negedge Clk);

    // Nominal acquisition: lock at the 2nd VS fall, frame_cnt 2 after the 3rd
    send_frame(VS, -1, HT, HS, 0, 1'b0, 1'b0);
    chk("locked after 1 fall", locked, 0);
    send_frame(VS, -1, HT, HS, 1, 1'b1, 1'b0);
    chk("locked after 2 falls", locked, 1);
    chk("frame_cnt after 2 falls", frame_cnt, 1);
    send_frame(VS, -1, HT, HS, 1, 1'b1, 1'b0);
    chk("frame_cnt after 3 falls", frame_cnt, 2);
    chk("hs_err nominal", hs_err_cnt, 0);
    chk("vs_err nominal", vs_err_cnt, 0);

    // One short line while locked, then relock after two clean VS falls
    send_frame(VS, 5, HT - 1, HS, -1, 1'b1, 1'b0);
    chk("hs_err short line", hs_err_cnt, 1);
    chk("locked short line", locked, 0);
    send_frame(VS, -1, HT, HS, 0, 1'b0, 1'b0);
    chk("locked rearm", locked, 0);
    send_frame(VS, -1, HT, HS, 1, 1'b1, 1'b0);
    chk("relocked", locked, 1);
    chk("frame_cnt relock", frame_cnt, 4);

    clr_err = 1'b1;
    @(negedge Clk);
    clr_err = 1'b0;
    chk("hs_err cleared", hs_err_cnt, 0);

    // Narrow HS in one frame, wide VS in the next
    send_frame(VS, 3, HT, HS - 1, -1, 1'b1, 1'b0);
    chk("hs_err narrow hs", hs_err_cnt, 1);
    chk("locked narrow hs", locked, 0);
    send_frame(VS + 1, -1, HT, HS, 0, 1'b0, 1'b0);
    chk("vs_err wide vs", vs_err_cnt, 1);
    chk("hs_err after wide vs", hs_err_cnt, 1);
    send_frame(VS, -1, HT, HS, 0, 1'b0, 1'b0);
    send_frame(VS, -1, HT, HS, 1, 1'b1, 1'b0);
    chk("locked after vs err", locked, 1);

    // Line timeout: no HS fall for 2*HT samples drops to the unlocked state
    for (int i = 0; i < 2 * HT; i++) drive(1'b1, 1'b1, 12'($urandom), 1'b0);
    chk("hs_err timeout", hs_err_cnt, 2);
    chk("locked timeout", locked, 0);
    // Errors are ignored while unlocked, which distinguishes it from acquiring
    send_line(100, HT, HS - 1, 0, 0, 1'b0, 1'b0);
    chk("hs_err ignored unlocked", hs_err_cnt, 2);
    send_frame(VS, -1, HT, HS, 0, 1'b0, 1'b0);
    send_frame(VS, -1, HT, HS, 1, 1'b1, 1'b0);
    chk("frame_cnt after timeout", frame_cnt, 7);

    // Clear coinciding with an HS width error: clear wins
    clr_v = 4;
    clr_h = HS - 1;
    send_frame(VS, 4, HT, HS - 1, -1, 1'b1, 1'b0);
    clr_v = -1;
    clr_h = -1;
    chk("hs_err clr wins", hs_err_cnt, 0);
    chk("vs_err clr wins", vs_err_cnt, 0);
    chk("locked after clr err", locked, 0);

    // Constant full-scale colour frame for the checksum
    send_frame(VS, -1, HT, HS, 0, 1'b0, 1'b1);
    send_frame(VS, -1, HT, HS, 1, 1'b1, 1'b0);
    chk("frame_sum const", frame_sum, exp_sum(16'hFEE0));
    chk("frame_cnt final", frame_cnt, 9);

    // Reset in the middle of a frame
    cur_sum = '0;
    for (int v = 0; v < 7; v++) send_line(v, HT, HS, VS, 1, v == 0, 1'b0);
    Reset_n = 1'b0;
    #1;
    check_zero("mid-frame reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
